// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// muldiv_iter_unit: iterative RV32M multiply (shift-add) / divide (restoring) unit.
// Optional macro MULDIV_EARLY_OUT_EN lets zero/overflow cases bypass the CALC phase.
module muldiv_iter_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    localparam int            CW       = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] SMIN   = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     data1_q, data1_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic                mz_q, mz_d;
    logic                done_q, done_d;

    // Request decode and operand preparation
    logic            w_op_valid, w_accept, w_in_div, w_in_rem, w_in_sdiv;
    logic            w_s1, w_s2, w_neg_in, w_dz_in, w_ovf_in, w_mz_in, w_early;
    logic [XLEN-1:0] w_abs1, w_abs2;

    assign w_op_valid = (ALUOP >= OP_MUL) && (ALUOP <= OP_REMU);
    assign w_accept   = START && w_op_valid && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign w_in_div   = (ALUOP >= OP_DIV);
    assign w_in_rem   = (ALUOP == OP_REM) || (ALUOP == OP_REMU);
    assign w_in_sdiv  = (ALUOP == OP_DIV) || (ALUOP == OP_REM);
    assign w_s1       = DATA1[XLEN-1] && ((ALUOP == OP_MULH) || (ALUOP == OP_MULHSU) || w_in_sdiv);
    assign w_s2       = DATA2[XLEN-1] && ((ALUOP == OP_MULH) || w_in_sdiv);
    assign w_abs1     = w_s1 ? -DATA1 : DATA1;
    assign w_abs2     = w_s2 ? -DATA2 : DATA2;
    assign w_neg_in   = w_in_rem ? w_s1 : (w_s1 ^ w_s2);
    assign w_dz_in    = w_in_div && (DATA2 == '0);
    assign w_ovf_in   = w_in_sdiv && (DATA1 == SMIN) && (DATA2 == '1);
    assign w_mz_in    = !w_in_div && ((DATA1 == '0) || (DATA2 == '0));
    assign w_early    = EARLY_EN && (w_dz_in || w_ovf_in || w_mz_in);

    // Iteration datapath
    logic            w_is_div, w_is_rem, w_qbit;
    logic [XLEN:0]   w_sum, w_shift, w_diff;

    assign w_is_div = (op_q >= OP_DIV);
    assign w_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    assign w_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign w_shift  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, opb_q};
    assign w_qbit   = ~w_diff[XLEN];

    // Sign fix-up and corner-case selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mres, w_dval, w_dres, w_fix_res;

    assign w_prod = neg_q ? -acc_q : acc_q;
    assign w_mres = (op_q == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_dval = w_is_rem ? rem_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_dres = neg_q ? -w_dval : w_dval;

    always_comb begin
        w_fix_res = w_mres;
        if (w_is_div) begin
            if (dz_q)       w_fix_res = w_is_rem ? data1_q : '1;
            else if (ovf_q) w_fix_res = w_is_rem ? '0 : SMIN;
            else            w_fix_res = w_dres;
        end else if (mz_q) begin
            w_fix_res = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        data1_d  = data1_q;
        res_d    = res_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        mz_d     = mz_q;
        done_d   = 1'b0;

        case (state_q)
            S_CALC: begin
                if (w_is_div) begin
                    rem_d = w_qbit ? w_diff : w_shift;
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], w_qbit};
                end else begin
                    acc_d = {w_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                res_d   = w_fix_res;
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d   = 1'b1;
                result_d = res_q;
                state_d  = S_IDLE;
            end
            default: ;
        endcase

        // Multiply keeps the multiplier in the low half; divide shifts the dividend out of it.
        if (w_accept) begin
            op_d    = ALUOP;
            data1_d = DATA1;
            cnt_d   = '0;
            rem_d   = '0;
            neg_d   = w_neg_in;
            dz_d    = w_dz_in;
            ovf_d   = w_ovf_in;
            mz_d    = w_mz_in;
            opb_d   = w_in_div ? w_abs2 : w_abs1;
            acc_d   = {{XLEN{1'b0}}, (w_in_div ? w_abs1 : w_abs2)};
            state_d = w_early ? S_FIX : S_CALC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            data1_q  <= '0;
            res_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            mz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            data1_q  <= data1_d;
            res_q    <= res_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            mz_q     <= mz_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
`default_nettype none
// tb_muldiv_iter_unit: randomized scoreboard bench with an arithmetic reference model.
module tb_muldiv_iter_unit;

    localparam logic [4:0] MUL = 5'b01011, MULH = 5'b01100, MULHSU = 5'b01101, MULHU = 5'b01110;
    localparam logic [4:0] DIV = 5'b01111, DIVU = 5'b10000, REM = 5'b10001, REMU = 5'b10010;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  aluop = '0;
    logic [31:0] d1 = '0, d2 = '0;
    logic [31:0] result;
    logic        busy, done;

    muldiv_iter_unit dut (
        .CLK(clk), .RESET(rst), .START(start), .ALUOP(aluop),
        .DATA1(d1), .DATA2(d2), .RESULT(result), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          edg;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          edge_cnt = 0;
    int          nvec = 0, nfail = 0;
    int          busy_lo = 0, busy_hi = -1, free_edge = 0;
    logic [31:0] hold = '0;
    bit          mon_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        int          ia = $signed(a);
        int          ib = $signed(b);
        case (op)
            MUL:    begin p = ua * ub;             return p[31:0];  end
            MULH:   begin p = sa * sb;             return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub);   return p[63:32]; end
            MULHU:  begin p = ua * ub;             return p[63:32]; end
            default: begin
                if (b == 0) return (op == REM || op == REMU) ? a : 32'hFFFF_FFFF;
                if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op == DIV) ? 32'h8000_0000 : 32'h0;
                case (op)
                    DIV:     return 32'(ia / ib);
                    REM:     return 32'(ia % ib);
                    DIVU:    return a / b;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_div = (op >= DIV);
        bit early  = (is_div && b == 0) ||
                     ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                     (!is_div && (a == 0 || b == 0));
        return early ? EARLY_LAT : 34;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 100));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: DONE must appear exactly at the predicted edge, RESULT must hold between completions.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].edg == edge_cnt) begin
                mon_e = sbq.pop_front();
                chk("done", {31'b0, done}, 32'd1);
                hold = mon_e.res;
            end else begin
                chk("done", {31'b0, done}, 32'd0);
            end
            chk("result", result, hold);
            chk("busy", {31'b0, busy}, {31'b0, (edge_cnt >= busy_lo && edge_cnt <= busy_hi)});
        end
    end

    // All driver tasks are entered at a falling edge and return at the next one.
    task automatic idle1();
        start = 1'b0;
        aluop = 5'($urandom);
        d1    = 32'($urandom);
        d2    = 32'($urandom);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t t;
        int   e;
        int   lat;
        start = 1'b1;
        aluop = op;
        d1    = a;
        d2    = b;
        e     = edge_cnt + 1;
        if (op >= MUL && op <= REMU && e >= free_edge) begin
            lat   = latency(op, a, b);
            t.res = ref_model(op, a, b);
            t.edg = e + lat;
            sbq.push_back(t);
            busy_lo   = e;
            busy_hi   = e + lat - 2;
            free_edge = e + lat;
        end
        @(negedge clk);
    endtask

    task automatic wait_free();
        while (edge_cnt + 1 < free_edge) idle1();
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_free();
        issue(op, a, b);
    endtask

    int a_edge;
    int r;
    logic [4:0] rop;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        run(MUL,    32'd7,          32'hFFFF_FFFD);
        run(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run(DIV,    32'hFFFF_FFEC,  32'd6);
        run(REM,    32'hFFFF_FFEC,  32'd6);
        run(DIVU,   32'd100,        32'd7);
        run(REMU,   32'd100,        32'd7);
        run(DIV,    32'd5,          32'd0);
        run(REMU,   32'd5,          32'd0);
        run(DIV,    32'h8000_0000,  32'hFFFF_FFFF);
        run(REM,    32'h8000_0000,  32'hFFFF_FFFF);
        wait_free();
        repeat (3) idle1();

        // Unsupported opcode is ignored
        issue(5'b00001, 32'd9, 32'd9);
        repeat (5) idle1();

        // START pulses while busy are dropped
        issue(MULH, 32'h8000_0001, 32'h1234_5678);
        repeat (3) idle1();
        issue(DIV, 32'd50, 32'd5);
        repeat (10) idle1();
        issue(REM, 32'd50, 32'd7);
        issue(MUL, 32'd2, 32'd3);
        wait_free();
        repeat (4) idle1();

        // Abort mid-calculation
        issue(MUL, 32'hDEAD_BEEF, 32'h1357_9BDF);
        a_edge = free_edge - latency(MUL, 32'hDEAD_BEEF, 32'h1357_9BDF);
        while (edge_cnt < a_edge + 10) idle1();
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        sbq.delete();
        hold      = '0;
        busy_hi   = -1;
        free_edge = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'h0);
        repeat (40) idle1();
        run(MUL, 32'd3, 32'd4);
        wait_free();
        repeat (3) idle1();

        // Randomized mix, including back-to-back and busy-time requests
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) rop = 5'(11 + r);
            else       rop = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 10)) : 5'($urandom_range(19, 31));
            case ($urandom_range(0, 3))
                0:       issue(rop, rnd_operand(), rnd_operand());
                1:       begin wait_free(); repeat ($urandom_range(0, 3)) idle1(); issue(rop, rnd_operand(), rnd_operand()); end
                default: run(rop, rnd_operand(), rnd_operand());
            endcase
        end

        wait_free();
        repeat (4) idle1();
        chk("pending", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
